// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared definitions for the byte-serial memory controller:
//               access-size encodings, FSM state type and a helper that maps
//               an access size to its byte count.
// Revision    : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

   // Access-size encodings shared with the MEM pipeline stage
   localparam logic [1:0] MEM_NOP  = 2'b00;
   localparam logic [1:0] MEM_BYTE = 2'b01;
   localparam logic [1:0] MEM_HALF = 2'b10;
   localparam logic [1:0] MEM_WORD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Number of RAM bytes moved for a given access size
   function automatic logic [2:0] sel_bytes(input logic [1:0] sel);
      case (sel)
         MEM_BYTE: sel_bytes = 3'd1;
         MEM_HALF: sel_bytes = 3'd2;
         MEM_WORD: sel_bytes = 3'd4;
         default:  sel_bytes = 3'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_ext.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_ext
// Description : Combinational load-result extension. BYTE results extend
//               bit 7, HALF results extend bit 15 (sign or zero depending on
//               i_sign); WORD results pass through unmodified.
// Ports       : i_word  - assembled little-endian word
//               i_sel   - access size encoding
//               i_sign  - 1 sign-extend, 0 zero-extend
//               o_word  - extended result
// Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl_ext
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_word,
   input  logic [1:0]        i_sel,
   input  logic              i_sign,
   output logic [DATA_W-1:0] o_word
);

   always_comb begin
      o_word = i_word;
      case (i_sel)
         MEM_BYTE: o_word = {{(DATA_W-8){i_sign & i_word[7]}}, i_word[7:0]};
         MEM_HALF: o_word = {{(DATA_W-16){i_sign & i_word[15]}}, i_word[15:0]};
         default:  o_word = i_word;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Arbitrates instruction-fetch and load/store requests onto a
//               byte-wide synchronous RAM. MEM requests win over IF. Each
//               access is serialised one byte per cycle, little-endian.
// Ports       : clk, rst        - clock, async active-high reset
//               if_req_i/if_addr_i/if_inst_o/if_done_o   - fetch port
//               mem_req_i/mem_we_i/mem_sel_i/mem_sign_i/
//               mem_addr_i/mem_wdata_i/mem_rdata_o/mem_done_o - load/store port
//               ram_addr_o/ram_din_i/ram_dout_o/ram_wr_o  - RAM byte port
// Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_inst_o,
   output logic              if_done_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_sel_i,
   input  logic              mem_sign_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              mem_done_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   input  logic [7:0]        ram_din_i,
   output logic [7:0]        ram_dout_o,
   output logic              ram_wr_o
);

   state_t              r_state;
   state_t              w_next;
   logic [2:0]          r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_sel;
   logic                r_sign;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_is_mem;
   logic [DATA_W-1:0]   r_buf;
   logic [DATA_W-1:0]   r_mem_rdata;
   logic [DATA_W-1:0]   r_if_inst;

   logic                w_accept_mem;
   logic                w_accept_if;
   logic [2:0]          w_nbytes;
   logic [ADDR_W-1:0]   w_byte_addr;
   logic [DATA_W-1:0]   w_wshift;
   logic [DATA_W-1:0]   w_merged;
   logic [DATA_W-1:0]   w_ext;

   assign w_nbytes    = sel_bytes(r_sel);
   assign w_byte_addr = r_addr + ADDR_W'(r_cnt);
   assign w_wshift    = r_wdata >> {r_cnt, 3'b000};
   // RAM data arrives one cycle after its address, so the byte on
   // ram_din_i in count c belongs to byte lane c-1. The last lane is merged
   // combinationally so the result register is loaded on the READ->DONE edge.
   assign w_merged    = r_buf | (DATA_W'(ram_din_i) << {r_cnt - 3'd1, 3'b000});

   mem_ctrl_ext #(
      .DATA_W (DATA_W)
   ) u_ext (
      .i_word (w_merged),
      .i_sel  (r_sel),
      .i_sign (r_sign),
      .o_word (w_ext)
   );

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and RAM/handshake outputs. Outputs decode only from state so
   // an asynchronous reset drops ram_wr_o immediately.
   // -------------------------------------------------------------------------
   always_comb begin
      w_next       = r_state;
      w_accept_mem = 1'b0;
      w_accept_if  = 1'b0;
      ram_addr_o   = '0;
      ram_dout_o   = '0;
      ram_wr_o     = 1'b0;
      if_done_o    = 1'b0;
      mem_done_o   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (mem_req_i && (mem_sel_i != MEM_NOP)) begin
               w_accept_mem = 1'b1;
               w_next       = mem_we_i ? ST_WRITE : ST_READ;
            end else if (if_req_i) begin
               w_accept_if  = 1'b1;
               w_next       = ST_READ;
            end
         end
         ST_READ: begin
            if (r_cnt < w_nbytes) begin
               ram_addr_o = w_byte_addr;
            end
            if (r_cnt == w_nbytes) begin
               w_next = ST_DONE;
            end
         end
         ST_WRITE: begin
            ram_addr_o = w_byte_addr;
            ram_dout_o = w_wshift[7:0];
            ram_wr_o   = 1'b1;
            if (r_cnt == (w_nbytes - 3'd1)) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            mem_done_o = r_is_mem;
            if_done_o  = ~r_is_mem;
            w_next     = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Request latch, byte counter and read assembly
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_addr      <= '0;
         r_sel       <= MEM_NOP;
         r_sign      <= 1'b0;
         r_wdata     <= '0;
         r_is_mem    <= 1'b0;
         r_buf       <= '0;
         r_mem_rdata <= '0;
         r_if_inst   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               r_buf <= '0;
               if (w_accept_mem) begin
                  r_addr   <= mem_addr_i;
                  r_sel    <= mem_sel_i;
                  r_sign   <= mem_sign_i;
                  r_wdata  <= mem_wdata_i;
                  r_is_mem <= 1'b1;
               end else if (w_accept_if) begin
                  // Fetches behave as unsigned word loads
                  r_addr   <= if_addr_i;
                  r_sel    <= MEM_WORD;
                  r_sign   <= 1'b0;
                  r_is_mem <= 1'b0;
               end
            end
            ST_READ: begin
               if (r_cnt != 3'd0) begin
                  r_buf <= w_merged;
               end
               if (r_cnt == w_nbytes) begin
                  r_cnt <= '0;
                  if (r_is_mem) begin
                     r_mem_rdata <= w_ext;
                  end else begin
                     r_if_inst   <= w_ext;
                  end
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            ST_WRITE: begin
               if (r_cnt == (w_nbytes - 3'd1)) begin
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign mem_rdata_o = r_mem_rdata;
   assign if_inst_o   = r_if_inst;

endmodule
`default_nettype wire
